// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Contents: FSM state encodings and the bit-counter width helper.
// Optional feature macro used by the block: SERIAL_SUB_OVF_EN (signed overflow flag).
package serial_sub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Counter width for a given operand width.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// Signals: start_valid/start_ready + a, b, bin (operand side),
//          res_valid/res_ready + diff, bout (result side), busy.
// Modports: master (operand producer / result consumer), slave (the subtractor).
// With SERIAL_SUB_OVF_EN defined, an extra ovf result flag is carried.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             busy;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;

   modport master (
      output start_valid, a, b, bin, res_ready,
      input  start_ready, res_valid, diff, bout, busy, ovf
   );
   modport slave (
      input  start_valid, a, b, bin, res_ready,
      output start_ready, res_valid, diff, bout, busy, ovf
   );
`else
   modport master (
      output start_valid, a, b, bin, res_ready,
      input  start_ready, res_valid, diff, bout, busy
   );
   modport slave (
      input  start_valid, a, b, bin, res_ready,
      output start_ready, res_valid, diff, bout, busy
   );
`endif
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational one-bit full subtractor: d = a - b - bin, borrow out in bout.
// Ports: a (minuend bit), b (subtrahend bit), bin (borrow in),
//        d (difference bit), bout (borrow out).
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one bit per clk.
// Ports: clk, rst (synchronous, active-high), bus (serial_subtractor_if.slave):
//    operand handshake start_valid/start_ready with a, b, bin;
//    result handshake res_valid/res_ready with diff, bout; busy in SHIFT/DONE.
// Optional macro SERIAL_SUB_OVF_EN adds bus.ovf, the signed overflow of a - b.
//
// state    | meaning
// ST_IDLE  | ready for operands, last result still visible
// ST_SHIFT | one bit of the difference per clock, WIDTH clocks
// ST_DONE  | result valid, held until res_ready
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   serial_subtractor_if.slave  bus
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, diff_r;
   logic             borrow, bout_r;
   logic [CNT_W-1:0] cnt;
   logic             d_bit, borrow_nxt;
   logic             accept, last_bit;
   logic             start_ready_c, res_valid_c, busy_c;

   full_subtractor u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (borrow),
      .d    (d_bit),
      .bout (borrow_nxt)
   );

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));
   assign accept   = (state == ST_IDLE) && bus.start_valid;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      start_ready_c = 1'b0;
      res_valid_c   = 1'b0;
      busy_c        = 1'b0;
      case (state)
         ST_IDLE: begin
            start_ready_c = 1'b1;
            if (bus.start_valid) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            busy_c = 1'b1;
            if (last_bit) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            busy_c      = 1'b1;
            res_valid_c = 1'b1;
            if (bus.res_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

`ifdef SERIAL_SUB_OVF_EN
   logic ovf_r;
   // On the MSB step a_sh[0]/b_sh[0] are the original sign bits and d_bit is diff's sign.
   always_ff @(posedge clk) begin
      if (rst)                              ovf_r <= 1'b0;
      else if (state == ST_SHIFT && last_bit)
         ovf_r <= (a_sh[0] != b_sh[0]) && (d_bit != a_sh[0]);
   end
   assign bus.ovf = ovf_r;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         diff_r <= '0;
         borrow <= 1'b0;
         bout_r <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_sh   <= bus.a;
                  b_sh   <= bus.b;
                  borrow <= bus.bin;
                  cnt    <= '0;
               end
            end
            ST_SHIFT: begin
               diff_r <= {d_bit, diff_r[WIDTH-1:1]};
               a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
               borrow <= borrow_nxt;
               cnt    <= cnt + CNT_W'(1);
               if (last_bit) bout_r <= borrow_nxt;
            end
            default: ;
         endcase
      end
   end

   assign bus.start_ready = start_ready_c;
   assign bus.res_valid   = res_valid_c;
   assign bus.busy        = busy_c;
   assign bus.diff        = diff_r;
   assign bus.bout        = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH = 8): stimulus pushes the
// hand-computed expected result at each accept, a negedge monitor pops and
// compares on every result handshake and watches latency, hold and spacing.
// SERIAL_SUB_OVF_EN, when defined, also checks the ovf flag.
module tb_serial_subtractor;
   import serial_sub_pkg::*;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] d;
      logic         b;
      logic         o;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   nchk = 0;
   int   nerr = 0;

   exp_t q[$];

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      nchk++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor state
   logic         prev_rv = 1'b0, prev_hs = 1'b0, prev_hold = 1'b0;
   logic [W-1:0] held_d = '0;
   logic         held_b = 1'b0;
   int           last_acc = 0;
   bit           chk_spacing = 1'b0, spacing_armed = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_rv   = 1'b0;
         prev_hs   = 1'b0;
         prev_hold = 1'b0;
      end else begin
         if (prev_hs) check("res_valid_one_cycle", bus.res_valid, 1'b0);
         if (bus.start_valid && bus.start_ready) begin
            if (chk_spacing && spacing_armed)
               check("accept_spacing", cyc + 1 - last_acc, W + 2);
            spacing_armed = 1'b1;
            last_acc = cyc + 1;
         end
         if (bus.res_valid && !prev_rv) check("latency", cyc - last_acc, W);
         if (bus.res_valid) begin
            check("start_ready_in_done", bus.start_ready, 1'b0);
            check("busy_in_done", bus.busy, 1'b1);
         end
         if (bus.res_valid && prev_hold) begin
            check("hold_diff", bus.diff, held_d);
            check("hold_bout", bus.bout, held_b);
         end
         if (bus.res_valid && bus.res_ready) begin
            if (q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("diff", bus.diff, e.d);
               check("bout", bus.bout, e.b);
`ifdef SERIAL_SUB_OVF_EN
               check("ovf", bus.ovf, e.o);
`endif
            end
         end
         prev_hold = bus.res_valid && !bus.res_ready;
         held_d    = bus.diff;
         held_b    = bus.bout;
         prev_rv   = bus.res_valid;
         prev_hs   = bus.res_valid && bus.res_ready;
      end
   end

   // Present operands, wait for acceptance, optionally queue the expected result.
   // Leaves start_valid high; returns just after the accepting edge.
   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        input logic [W-1:0] ed, input logic eb, input logic eo, input bit push);
      int n;
      exp_t e;
      bus.start_valid = 1'b1;
      bus.a           = ia;
      bus.b           = ib;
      bus.bin         = ibin;
      n = 0;
      @(negedge clk);
      while (!bus.start_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.start_ready) begin
         check("accept_timeout", 0, 1);
      end else if (push) begin
         e.d = ed;
         e.b = eb;
         e.o = eo;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         check("drain_timeout", q.size(), 0);
         q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.start_valid = 1'b0;
      bus.a           = '0;
      bus.b           = '0;
      bus.bin         = 1'b0;
      bus.res_ready   = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_res_valid", bus.res_valid, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_diff", bus.diff, 8'h00);
      check("rst_bout", bus.bout, 1'b0);
      check("rst_start_ready", bus.start_ready, 1'b1);
      @(posedge clk);
      #1;

      // Basic results
      issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
      bus.start_valid = 1'b0;
      drain();
      issue(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1);
      bus.start_valid = 1'b0;
      drain();
      issue(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
      bus.start_valid = 1'b0;
      drain();

      // Backpressure with spurious start pulses in DONE
      bus.res_ready = 1'b0;
      issue(8'h40, 8'h22, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b1);
      bus.start_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!bus.res_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp_res_valid_seen", bus.res_valid, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         bus.start_valid = (i % 2 == 0);
         bus.a           = 8'h11;
         bus.b           = 8'h01;
         bus.bin         = 1'b0;
      end
      @(posedge clk);
      #1;
      bus.start_valid = 1'b0;
      bus.res_ready   = 1'b1;
      drain();
      issue(8'h22, 8'h11, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
      bus.start_valid = 1'b0;
      drain();

      // Reset during the third SHIFT cycle
      issue(8'h33, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      bus.start_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_res_valid", bus.res_valid, 1'b0);
      check("mid_rst_busy", bus.busy, 1'b0);
      check("mid_rst_diff", bus.diff, 8'h00);
      check("mid_rst_start_ready", bus.start_ready, 1'b1);
      @(posedge clk);
      #1;
      issue(8'hA0, 8'h01, 1'b0, 8'h9F, 1'b0, 1'b0, 1'b1);
      bus.start_valid = 1'b0;
      drain();

      // Back-to-back with start_valid held high
      chk_spacing   = 1'b1;
      spacing_armed = 1'b0;
      issue(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
      issue(8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
      issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
      issue(8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1);
      issue(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
      bus.start_valid = 1'b0;
      drain();
      chk_spacing = 1'b0;

      // Signed overflow corner cases (diff/bout checked in every build)
      issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1);
      bus.start_valid = 1'b0;
      drain();
      issue(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
      bus.start_valid = 1'b0;
      drain();
      issue(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1);
      bus.start_valid = 1'b0;
      drain();

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
